// File: rtl/c432_key_loader.sv
// c432_key_loader: serial key intake with even-parity check for the c432 key bus.
// Optional lockout after MAX_FAIL failed loads: define KEY_LOADER_LOCKOUT_EN.
module c432_key_loader #(
  parameter int               KEY_W    = 4,
  parameter logic [KEY_W-1:0] DECOY    = '0,
  parameter int               TIMEOUT  = 64,
  parameter int               MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             ser_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_ok,
  output logic             busy,
  output logic             err,
  output logic             locked
);

  localparam int FW  = KEY_W + 1;
  localparam int CW  = $clog2(FW + 1);
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int FCW = (MAX_FAIL > 0) ? $clog2(MAX_FAIL + 1) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_ARMED   = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;
  localparam logic [2:0] S_LOCKOUT = 3'd5;

  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic [FW-1:0] sr_q;
  logic [CW-1:0] bit_cnt_q;
  logic [TW-1:0] idle_q;
  logic [FCW-1:0] fail_q;
  logic [FCW-1:0] fail_inc;

  logic accept;
  logic last_bit;
  logic timeout_hit;
  logic parity_ok;
  logic to_err;
  logic lock_hit;
  logic enter_load;

  assign ser_ready = (state_q == S_LOAD);
  assign busy      = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign err       = (state_q == S_ERROR) || (state_q == S_LOCKOUT);

  assign accept    = ser_ready && ser_valid;
  assign last_bit  = accept && (bit_cnt_q == CW'(FW - 1));
  assign parity_ok = ~^sr_q;

  assign timeout_hit = (TIMEOUT != 0) && ser_ready && !accept &&
                       (idle_q == TW'(TIMEOUT - 1));

  assign fail_inc = (fail_q == FCW'(MAX_FAIL)) ? fail_q : fail_q + 1'b1;

`ifdef KEY_LOADER_LOCKOUT_EN
  assign lock_hit = (fail_inc == FCW'(MAX_FAIL));
  assign locked   = (state_q == S_LOCKOUT);
`else
  assign lock_hit = 1'b0;
  assign locked   = 1'b0;
`endif

  // next-state decode; LOAD/CHECK ignore start, LOCKOUT only leaves on rst
  always_comb begin
    state_d = state_q;
    to_err  = 1'b0;
    unique case (state_q)
      S_IDLE, S_ARMED, S_ERROR: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (last_bit)         state_d = S_CHECK;
        else if (timeout_hit) to_err  = 1'b1;
      end
      S_CHECK: begin
        if (parity_ok) state_d = S_ARMED;
        else           to_err  = 1'b1;
      end
      S_LOCKOUT: state_d = S_LOCKOUT;
      default:   state_d = S_IDLE;
    endcase
    if (to_err) state_d = lock_hit ? S_LOCKOUT : S_ERROR;
  end

  assign enter_load = (state_d == S_LOAD) && (state_q != S_LOAD);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // shift register, bit count and idle counter; partial keys die on error
  always_ff @(posedge clk) begin
    if (rst || enter_load || to_err) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
      idle_q    <= '0;
    end else if (accept) begin
      sr_q      <= {ser_data, sr_q[FW-1:1]};
      bit_cnt_q <= bit_cnt_q + 1'b1;
      idle_q    <= '0;
    end else if (ser_ready) begin
      idle_q    <= idle_q + 1'b1;
    end
  end

  // key bus: registered, only ever loaded from a frame that passed parity
  always_ff @(posedge clk) begin
    if (rst) begin
      key_out <= DECOY;
      key_ok  <= 1'b0;
    end else if ((state_q == S_CHECK) && parity_ok) begin
      key_out <= sr_q[KEY_W-1:0];
      key_ok  <= 1'b1;
    end else if (state_d != S_ARMED) begin
      key_out <= DECOY;
      key_ok  <= 1'b0;
    end
  end

  // failed-load counter: saturating, cleared by a verified load
  always_ff @(posedge clk) begin
    if (rst)                                           fail_q <= '0;
    else if (to_err)                                   fail_q <= fail_inc;
    else if ((state_d == S_ARMED) && (state_q != S_ARMED)) fail_q <= '0;
  end

endmodule
